// File: rtl/u712_cycle_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// u712_cycle_seq : chip register / chip RAM CPU cycle sequencer gated by Agnus DMA
// Define U712_SEQ_TIMEOUT_EN to enable the DMA-wait timeout with BERR. Rev 1.0
// ----------------------------------------------------------------------------
module u712_cycle_seq #(
  parameter int REG_CLKS = 4,
  parameter int RAM_CLKS = 6,
  parameter int TMO_CLKS = 255
) (
  input  logic CLK40,
  input  logic RESETn,
  input  logic REG_REQ,
  input  logic RAM_REQ,
  input  logic RnW,
  input  logic CASUn,
  input  logic CASLn,
  output logic REG_CYCLE,
  output logic CPU_CYCLE,
  output logic CYCLE_RnW,
  output logic CYCLE_ACK,
  output logic BUSY,
  output logic BERR
);

  if (REG_CLKS < 2 || REG_CLKS > 15) begin : g_bad_reg_clks
    $error("REG_CLKS out of range 2..15");
  end
  if (RAM_CLKS < 2 || RAM_CLKS > 15) begin : g_bad_ram_clks
    $error("RAM_CLKS out of range 2..15");
  end
  if (TMO_CLKS < 1 || TMO_CLKS > 255) begin : g_bad_tmo_clks
    $error("TMO_CLKS out of range 1..255");
  end

  localparam logic [3:0] REG_LOAD = 4'(REG_CLKS - 1);
  localparam logic [3:0] RAM_LOAD = 4'(RAM_CLKS - 1);

`ifdef U712_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DMA = 3'd1,
    ACTIVE   = 3'd2,
    ACK      = 3'd3,
    ERR      = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DMA = 3'd1,
    ACTIVE   = 3'd2,
    ACK      = 3'd3
  } state_t;
`endif

  state_t     state, state_nxt;
  logic       is_reg, is_reg_nxt;
  logic       rnw_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       reg_cycle_nxt, cpu_cycle_nxt, ack_nxt, busy_nxt, berr_nxt;

  // CAS strobes are asynchronous to CLK40; idle level is high
  logic casu_meta, casu_sync, casl_meta, casl_sync;
  logic dma_busy;

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      casu_meta <= 1'b1;
      casu_sync <= 1'b1;
      casl_meta <= 1'b1;
      casl_sync <= 1'b1;
    end else begin
      casu_meta <= CASUn;
      casu_sync <= casu_meta;
      casl_meta <= CASLn;
      casl_sync <= casl_meta;
    end
  end

  assign dma_busy = !casu_sync || !casl_sync;

`ifdef U712_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt, wait_cnt_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    is_reg_nxt = is_reg;
    rnw_nxt    = CYCLE_RnW;
    cnt_nxt    = cnt;
`ifdef U712_SEQ_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (REG_REQ || RAM_REQ) begin
          is_reg_nxt = REG_REQ;
          rnw_nxt    = RnW;
          state_nxt  = WAIT_DMA;
`ifdef U712_SEQ_TIMEOUT_EN
          wait_cnt_nxt = 8'd0;
`endif
        end
      end
      WAIT_DMA: begin
        if (!dma_busy) begin
          state_nxt = ACTIVE;
          cnt_nxt   = is_reg ? REG_LOAD : RAM_LOAD;
        end
`ifdef U712_SEQ_TIMEOUT_EN
        else if (wait_cnt == TMO_LAST) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
`endif
      end
      // DMA activity is deliberately not looked at once the cycle has started
      ACTIVE: begin
        if (cnt == 4'd0) begin
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK: state_nxt = IDLE;
`ifdef U712_SEQ_TIMEOUT_EN
      ERR: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase

    reg_cycle_nxt = (state_nxt == ACTIVE) && is_reg_nxt;
    cpu_cycle_nxt = (state_nxt == ACTIVE) && !is_reg_nxt;
    ack_nxt       = (state_nxt == ACK);
    busy_nxt      = (state_nxt != IDLE);
`ifdef U712_SEQ_TIMEOUT_EN
    berr_nxt      = (state_nxt == ERR);
`else
    berr_nxt      = 1'b0;
`endif
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state     <= IDLE;
      is_reg    <= 1'b0;
      cnt       <= 4'd0;
      REG_CYCLE <= 1'b0;
      CPU_CYCLE <= 1'b0;
      CYCLE_RnW <= 1'b1;
      CYCLE_ACK <= 1'b0;
      BUSY      <= 1'b0;
      BERR      <= 1'b0;
    end else begin
      state     <= state_nxt;
      is_reg    <= is_reg_nxt;
      cnt       <= cnt_nxt;
      REG_CYCLE <= reg_cycle_nxt;
      CPU_CYCLE <= cpu_cycle_nxt;
      CYCLE_RnW <= rnw_nxt;
      CYCLE_ACK <= ack_nxt;
      BUSY      <= busy_nxt;
      BERR      <= berr_nxt;
    end
  end

`ifdef U712_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
    end
  end
`endif

endmodule
`default_nettype wire
